// File: rtl/cpu_hazard_pkg.sv
// Shared encodings for the hazard/forward unit: forward-select codes and
// the long-unit scoreboard FSM states.
package cpu_hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10,
      FWD_ALT = 2'b11
   } fwd_sel_e;

   typedef enum logic [1:0] {
      LU_IDLE = 2'b00,
      LU_BUSY = 2'b01,
      LU_DONE = 2'b10
   } lu_state_e;

endpackage

// File: rtl/hazard_port_match.sv
// Stall/forward decision for one source operand against the younger
// pipeline stages (previous stage, MEM, WB) and an alternate producer.
module hazard_port_match
   import cpu_hazard_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] src_i,
   input  logic             want_i,
   input  logic             need_i,
   input  logic [REG_W-1:0] prev_dst_i,
   input  logic             prev_regwrite_i,
   input  logic [REG_W-1:0] mem_dst_i,
   input  logic             mem_regwrite_i,
   input  logic             mem_access_i,
   input  logic [REG_W-1:0] wb_dst_i,
   input  logic             wb_regwrite_i,
   input  logic [REG_W-1:0] alt_dst_i,
   input  logic             alt_valid_i,
   output logic             stall_o,
   output logic [1:0]       fwd_sel_o
);

   function automatic logic hit(input logic [REG_W-1:0] s,
                                input logic [REG_W-1:0] d,
                                input logic             we);
      return (s == d) && (d != '0) && we;
   endfunction

   logic use_w;
   logic prev_hit, mem_hit, wb_hit, alt_hit;

   assign use_w    = want_i | need_i;
   assign prev_hit = use_w & hit(src_i, prev_dst_i, prev_regwrite_i);
   assign mem_hit  = use_w & hit(src_i, mem_dst_i, mem_regwrite_i);
   assign wb_hit   = use_w & hit(src_i, wb_dst_i, wb_regwrite_i);
   assign alt_hit  = use_w & hit(src_i, alt_dst_i, alt_valid_i);

   assign stall_o = need_i & (prev_hit | (mem_hit & mem_access_i));

   // A MEM match shadows older producers even when its data is not ready yet.
   always_comb begin
      fwd_sel_o = FWD_RF;
      if (mem_hit)
         fwd_sel_o = mem_access_i ? FWD_RF : FWD_MEM;
      else if (wb_hit)
         fwd_sel_o = FWD_WB;
      else if (alt_hit)
         fwd_sel_o = FWD_ALT;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard/forward unit with a scoreboard for one long-latency unit.
// Optional stall performance counters: define HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard
   import cpu_hazard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int NUM_SRC  = 2,
   parameter int MAX_LAT  = 32,
   parameter int LAT_W    = 6
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_SRC*REG_W-1:0] id_src,
   input  logic [NUM_SRC-1:0]       id_want,
   input  logic [NUM_SRC-1:0]       id_need,
   input  logic [NUM_SRC*REG_W-1:0] ex_src,
   input  logic [NUM_SRC-1:0]       ex_want,
   input  logic [NUM_SRC-1:0]       ex_need,
   input  logic [REG_W-1:0]         ex_dst,
   input  logic [REG_W-1:0]         mem_dst,
   input  logic [REG_W-1:0]         wb_dst,
   input  logic                     ex_regwrite,
   input  logic                     mem_regwrite,
   input  logic                     wb_regwrite,
   input  logic                     mem_access,
   input  logic [REG_W-1:0]         mem_st_src,
   input  logic                     ex_link,
   input  logic                     lu_issue,
   input  logic [REG_W-1:0]         lu_dst,
   input  logic [LAT_W-1:0]         lu_lat,
   input  logic                     imem_busy,
   input  logic                     dmem_stall,
   output logic                     if_stall,
   output logic                     id_stall,
   output logic                     ex_stall,
   output logic                     mem_stall,
   output logic                     wb_stall,
   output logic [NUM_SRC*2-1:0]     id_fwd_sel,
   output logic [NUM_SRC*2-1:0]     ex_fwd_sel,
   output logic                     mem_wdata_fwd,
   output logic                     lu_wb_valid,
   output logic [REG_W-1:0]         lu_wb_dst,
   output logic [NUM_REGS-1:0]      busy_mask
`ifdef HAZARD_SCOREBOARD_PERF_EN
   ,
   output logic [31:0]              perf_id_stall_cnt,
   output logic [31:0]              perf_ex_stall_cnt,
   output logic [31:0]              perf_lu_stall_cnt
`endif
);

   function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] l);
      if (l == '0)
         return LAT_W'(1);
      else if (l > LAT_W'(MAX_LAT))
         return LAT_W'(MAX_LAT);
      else
         return l;
   endfunction

   function automatic logic [NUM_REGS-1:0] dst_mask(input logic [REG_W-1:0] d);
      logic [NUM_REGS-1:0] m;
      m = '0;
      if (d != '0)
         m[d] = 1'b1;
      return m;
   endfunction

   lu_state_e           state_q, state_d;
   logic [LAT_W-1:0]    cnt_q, cnt_d;
   logic [REG_W-1:0]    pend_q, pend_d;
   logic [NUM_REGS-1:0] busy_mask_q, busy_mask_d;

   logic [NUM_SRC-1:0]   id_port_stall, ex_port_stall, need_busy;
   logic [NUM_SRC*2-1:0] ex_port_fwd;
   logic                 id_term, ex_term, sb_term;
   logic                 lu_busy, lu_done, issue_ok;
   logic [LAT_W-1:0]     lat_eff;

   assign lu_busy = (state_q == LU_BUSY);
   assign lu_done = (state_q == LU_DONE);

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_port
      hazard_port_match #(.REG_W(REG_W)) u_id_match (
         .src_i          (id_src[k*REG_W +: REG_W]),
         .want_i         (id_want[k]),
         .need_i         (id_need[k]),
         .prev_dst_i     (ex_dst),
         .prev_regwrite_i(ex_regwrite),
         .mem_dst_i      (mem_dst),
         .mem_regwrite_i (mem_regwrite),
         .mem_access_i   (mem_access),
         .wb_dst_i       (wb_dst),
         .wb_regwrite_i  (wb_regwrite),
         .alt_dst_i      (pend_q),
         .alt_valid_i    (lu_done),
         .stall_o        (id_port_stall[k]),
         .fwd_sel_o      (id_fwd_sel[2*k +: 2])
      );

      // EX has no younger in-pipe producer and no long-unit bypass.
      hazard_port_match #(.REG_W(REG_W)) u_ex_match (
         .src_i          (ex_src[k*REG_W +: REG_W]),
         .want_i         (ex_want[k]),
         .need_i         (ex_need[k]),
         .prev_dst_i     ({REG_W{1'b0}}),
         .prev_regwrite_i(1'b0),
         .mem_dst_i      (mem_dst),
         .mem_regwrite_i (mem_regwrite),
         .mem_access_i   (mem_access),
         .wb_dst_i       (wb_dst),
         .wb_regwrite_i  (wb_regwrite),
         .alt_dst_i      ({REG_W{1'b0}}),
         .alt_valid_i    (1'b0),
         .stall_o        (ex_port_stall[k]),
         .fwd_sel_o      (ex_port_fwd[2*k +: 2])
      );

      assign need_busy[k] = id_need[k] & busy_mask_q[id_src[k*REG_W +: REG_W]];
   end

   assign ex_fwd_sel    = ex_link ? '1 : ex_port_fwd;
   assign mem_wdata_fwd = (mem_st_src == wb_dst) & (wb_dst != '0) & wb_regwrite;

   // lu_dst doubles as the ID destination field for the WAW check.
   assign id_term = |id_port_stall;
   assign ex_term = |ex_port_stall;
   assign sb_term = (|need_busy)
                  | (lu_issue & lu_busy)
                  | (lu_busy & (pend_q != '0) & (lu_dst == pend_q));

   assign if_stall  = imem_busy;
   assign mem_stall = if_stall | dmem_stall;
   assign wb_stall  = mem_stall;
   assign ex_stall  = ex_term | mem_stall;
   assign id_stall  = id_term | sb_term | ex_stall;

   assign issue_ok = lu_issue & ~id_stall;
   assign lat_eff  = sat_lat(lu_lat);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      busy_mask_d = busy_mask_q;
      unique case (state_q)
         LU_IDLE: begin
            if (issue_ok) begin
               pend_d      = lu_dst;
               cnt_d       = lat_eff;
               busy_mask_d = dst_mask(lu_dst);
               state_d     = (lat_eff == LAT_W'(1)) ? LU_DONE : LU_BUSY;
            end
         end
         LU_BUSY: begin
            if (!wb_stall) begin
               cnt_d = cnt_q - LAT_W'(1);
               if (cnt_q == LAT_W'(2))
                  state_d = LU_DONE;
            end
         end
         LU_DONE: begin
            if (!wb_stall) begin
               if (issue_ok) begin
                  pend_d      = lu_dst;
                  cnt_d       = lat_eff;
                  busy_mask_d = dst_mask(lu_dst);
                  state_d     = (lat_eff == LAT_W'(1)) ? LU_DONE : LU_BUSY;
               end else begin
                  cnt_d       = '0;
                  busy_mask_d = '0;
                  state_d     = LU_IDLE;
               end
            end
         end
         default: state_d = LU_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= LU_IDLE;
         cnt_q       <= '0;
         pend_q      <= '0;
         busy_mask_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         busy_mask_q <= busy_mask_d;
      end
   end

   assign lu_wb_valid = lu_done;
   assign lu_wb_dst   = pend_q;
   assign busy_mask   = busy_mask_q;

`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0] perf_id_q, perf_ex_q, perf_lu_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_id_q <= '0;
         perf_ex_q <= '0;
         perf_lu_q <= '0;
      end else begin
         if (id_term && (perf_id_q != '1)) perf_id_q <= perf_id_q + 32'd1;
         if (ex_term && (perf_ex_q != '1)) perf_ex_q <= perf_ex_q + 32'd1;
         if (sb_term && (perf_lu_q != '1)) perf_lu_q <= perf_lu_q + 32'd1;
      end
   end

   assign perf_id_stall_cnt = perf_id_q;
   assign perf_ex_stall_cnt = perf_ex_q;
   assign perf_lu_stall_cnt = perf_lu_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; long-unit writebacks are checked
// against a queue of expected (destination, cycle) entries.
module tb_hazard_scoreboard;

   localparam int NUM_REGS = 32;
   localparam int REG_W    = 5;
   localparam int NUM_SRC  = 2;
   localparam int MAX_LAT  = 32;
   localparam int LAT_W    = 6;

   logic clock = 1'b0;
   logic reset;
   logic [NUM_SRC*REG_W-1:0] id_src, ex_src;
   logic [NUM_SRC-1:0]       id_want, id_need, ex_want, ex_need;
   logic [REG_W-1:0]         ex_dst, mem_dst, wb_dst, mem_st_src, lu_dst;
   logic                     ex_regwrite, mem_regwrite, wb_regwrite, mem_access, ex_link;
   logic                     lu_issue, imem_busy, dmem_stall;
   logic [LAT_W-1:0]         lu_lat;
   logic                     if_stall, id_stall, ex_stall, mem_stall, wb_stall;
   logic [NUM_SRC*2-1:0]     id_fwd_sel, ex_fwd_sel;
   logic                     mem_wdata_fwd, lu_wb_valid;
   logic [REG_W-1:0]         lu_wb_dst;
   logic [NUM_REGS-1:0]      busy_mask;
`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0]              perf_id_stall_cnt, perf_ex_stall_cnt, perf_lu_stall_cnt;
`endif

   hazard_scoreboard #(
      .NUM_REGS(NUM_REGS), .REG_W(REG_W), .NUM_SRC(NUM_SRC),
      .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)
   ) dut (
      .clock(clock), .reset(reset),
      .id_src(id_src), .id_want(id_want), .id_need(id_need),
      .ex_src(ex_src), .ex_want(ex_want), .ex_need(ex_need),
      .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
      .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
      .mem_access(mem_access), .mem_st_src(mem_st_src), .ex_link(ex_link),
      .lu_issue(lu_issue), .lu_dst(lu_dst), .lu_lat(lu_lat),
      .imem_busy(imem_busy), .dmem_stall(dmem_stall),
      .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
      .mem_stall(mem_stall), .wb_stall(wb_stall),
      .id_fwd_sel(id_fwd_sel), .ex_fwd_sel(ex_fwd_sel),
      .mem_wdata_fwd(mem_wdata_fwd), .lu_wb_valid(lu_wb_valid),
      .lu_wb_dst(lu_wb_dst), .busy_mask(busy_mask)
`ifdef HAZARD_SCOREBOARD_PERF_EN
      ,
      .perf_id_stall_cnt(perf_id_stall_cnt),
      .perf_ex_stall_cnt(perf_ex_stall_cnt),
      .perf_lu_stall_cnt(perf_lu_stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic [REG_W-1:0] dst;
      int               at;
   } lu_exp_t;
   lu_exp_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_lu(input logic [REG_W-1:0] dst, input int at);
      exp_q.push_back('{dst: dst, at: at});
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      id_src = '0; id_want = '0; id_need = '0;
      ex_src = '0; ex_want = '0; ex_need = '0;
      ex_dst = '0; mem_dst = '0; wb_dst = '0; mem_st_src = '0;
      ex_regwrite = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
      mem_access = 1'b0; ex_link = 1'b0;
      lu_issue = 1'b0; lu_dst = '0; lu_lat = '0;
      imem_busy = 1'b0; dmem_stall = 1'b0;
   endtask

   // Writeback monitor: each completing DONE cycle must match the queue head.
   always @(negedge clock) begin
      if (!reset && lu_wb_valid && !wb_stall) begin
         if (exp_q.size() == 0) begin
            chk("lu_wb_unexpected", 64'(lu_wb_valid), 64'd0);
         end else begin
            lu_exp_t e;
            e = exp_q.pop_front();
            chk("lu_wb_dst", 64'(lu_wb_dst), 64'(e.dst));
            chk("lu_wb_cycle", 64'(cyc), 64'(e.at));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      reset = 1'b1;
      idle();
      repeat (2) tick();
      reset = 1'b0;
      #1;
      chk("rst_busy_mask", 64'(busy_mask), 64'd0);
      chk("rst_lu_wb_valid", 64'(lu_wb_valid), 64'd0);
      chk("rst_lu_wb_dst", 64'(lu_wb_dst), 64'd0);
      chk("rst_stalls", 64'({if_stall, id_stall, ex_stall, mem_stall, wb_stall}), 64'd0);
      chk("rst_fwd", 64'({id_fwd_sel, ex_fwd_sel}), 64'd0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
      chk("rst_perf", 64'({perf_id_stall_cnt | perf_ex_stall_cnt | perf_lu_stall_cnt}), 64'd0);
`endif

      // ID against EX
      tick();
      id_src = {5'd0, 5'd3}; id_need = 2'b01; ex_dst = 5'd3; ex_regwrite = 1'b1;
      #1;
      chk("id_need_ex_stall", 64'(id_stall), 64'd1);
      chk("id_need_ex_exstall", 64'(ex_stall), 64'd0);
      chk("id_need_ex_fwd", 64'(id_fwd_sel[1:0]), 64'd0);
      id_need = 2'b00; id_want = 2'b01;
      #1;
      chk("id_want_ex_nostall", 64'(id_stall), 64'd0);
      id_need = 2'b01; id_src = '0; ex_dst = '0;
      #1;
      chk("id_r0_nostall", 64'(id_stall), 64'd0);

      // EX against MEM/WB
      tick(); idle();
      ex_src = {5'd5, 5'd0}; ex_want = 2'b10;
      mem_dst = 5'd5; mem_regwrite = 1'b1; wb_dst = 5'd5; wb_regwrite = 1'b1;
      #1;
      chk("ex_fwd_mem", 64'(ex_fwd_sel), 64'b0100);
      chk("ex_fwd_mem_nostall", 64'(ex_stall), 64'd0);
      mem_access = 1'b1; ex_need = 2'b10;
      #1;
      chk("ex_load_stall", 64'(ex_stall), 64'd1);
      chk("ex_load_idstall", 64'(id_stall), 64'd1);
      mem_access = 1'b0; ex_need = 2'b00; mem_regwrite = 1'b0;
      #1;
      chk("ex_fwd_wb", 64'(ex_fwd_sel), 64'b1000);
      ex_link = 1'b1;
      #1;
      chk("ex_link", 64'(ex_fwd_sel), 64'b1111);
      ex_link = 1'b0;

      // ID against MEM/WB, store-data forward
      mem_regwrite = 1'b1; mem_dst = 5'd6; id_src = {5'd5, 5'd6}; id_want = 2'b11;
      #1;
      chk("id_fwd_mem_wb", 64'(id_fwd_sel), 64'b1001);
      mem_st_src = 5'd5;
      #1;
      chk("wdata_fwd_hit", 64'(mem_wdata_fwd), 64'd1);
      wb_regwrite = 1'b0;
      #1;
      chk("wdata_fwd_nowrite", 64'(mem_wdata_fwd), 64'd0);

      // Stall chain
      idle(); imem_busy = 1'b1;
      #1;
      chk("chain_imem", 64'({if_stall, id_stall, ex_stall, mem_stall, wb_stall}), 64'b11111);
      imem_busy = 1'b0; dmem_stall = 1'b1;
      #1;
      chk("chain_dmem", 64'({if_stall, id_stall, ex_stall, mem_stall, wb_stall}), 64'b01111);

      // Long unit, dst 7 latency 4
      tick(); idle();
      lu_issue = 1'b1; lu_dst = 5'd7; lu_lat = 6'd4; c0 = cyc;
      expect_lu(5'd7, c0 + 4);
      #1;
      chk("lu_issue_accept", 64'(id_stall), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         tick(); idle();
         id_src = {5'd7, 5'd7}; id_need = 2'b01; id_want = 2'b10;
         #1;
         chk("lu_busy_mask", 64'(busy_mask), 64'(32'd1 << 7));
         chk("lu_need_stall", 64'(id_stall), 64'd1);
         if (i == 4) begin
            chk("lu_done_valid", 64'(lu_wb_valid), 64'd1);
            chk("lu_done_fwd", 64'(id_fwd_sel), 64'b1111);
         end else begin
            chk("lu_busy_valid", 64'(lu_wb_valid), 64'd0);
            chk("lu_busy_fwd", 64'(id_fwd_sel), 64'd0);
         end
      end
      tick(); idle();
      id_src = {5'd0, 5'd7}; id_need = 2'b01;
      #1;
      chk("lu_mask_cleared", 64'(busy_mask), 64'd0);
      chk("lu_released", 64'(id_stall), 64'd0);

      // Structural stall, back-to-back issue in DONE, WAW
      tick(); idle();
      lu_issue = 1'b1; lu_dst = 5'd9; lu_lat = 6'd3; c0 = cyc;
      expect_lu(5'd9, c0 + 3);
      tick();
      lu_dst = 5'd10; lu_lat = 6'd2;
      #1;
      chk("lu_struct_stall1", 64'(id_stall), 64'd1);
      tick();
      chk("lu_struct_stall2", 64'(id_stall), 64'd1);
      tick();
      chk("lu_b2b_accept", 64'(id_stall), 64'd0);
      expect_lu(5'd10, c0 + 5);
      tick();
      lu_issue = 1'b0; lu_dst = 5'd10;
      #1;
      chk("lu_b2b_mask", 64'(busy_mask), 64'(32'd1 << 10));
      chk("lu_waw_stall", 64'(id_stall), 64'd1);
      lu_dst = 5'd11;
      #1;
      chk("lu_waw_nostall", 64'(id_stall), 64'd0);
      tick(); idle();
      tick();

      // Zero latency acts as one; MEM outranks the long-unit bypass
      tick(); idle();
      lu_issue = 1'b1; lu_dst = 5'd4; lu_lat = 6'd0;
      expect_lu(5'd4, cyc + 1);
      tick(); idle();
      id_src = {5'd0, 5'd4}; id_want = 2'b01; mem_dst = 5'd4; mem_regwrite = 1'b1;
      #1;
      chk("lu_lat0_done", 64'(lu_wb_valid), 64'd1);
      chk("lu_mem_beats_alt", 64'(id_fwd_sel), 64'b0001);

      // Register 0 destination with a saturated latency
      tick(); idle();
      lu_issue = 1'b1; lu_dst = 5'd0; lu_lat = 6'd50;
      expect_lu(5'd0, cyc + MAX_LAT);
      tick(); idle();
      lu_issue = 1'b1; lu_dst = 5'd12;
      #1;
      chk("lu_r0_mask", 64'(busy_mask), 64'd0);
      chk("lu_r0_struct", 64'(id_stall), 64'd1);
      lu_issue = 1'b0; lu_dst = 5'd0;
      repeat (30) tick();
      chk("lu_sat_not_done", 64'(lu_wb_valid), 64'd0);
      tick();
      chk("lu_sat_done", 64'(lu_wb_valid), 64'd1);

      // Memory stall freezes the latency counter for two cycles
      tick(); idle();
      lu_issue = 1'b1; lu_dst = 5'd6; lu_lat = 6'd3;
      expect_lu(5'd6, cyc + 5);
      tick(); idle();
      dmem_stall = 1'b1;
      tick();
      tick();
      dmem_stall = 1'b0;
      #1;
      chk("lu_dmem_hold1", 64'(lu_wb_valid), 64'd0);
      tick();
      chk("lu_dmem_hold2", 64'(lu_wb_valid), 64'd0);
      tick();
      chk("lu_dmem_done", 64'(lu_wb_valid), 64'd1);
      tick();

`ifdef HAZARD_SCOREBOARD_PERF_EN
      chk("perf_id_counted", 64'(perf_id_stall_cnt != 32'd0), 64'd1);
      chk("perf_ex_counted", 64'(perf_ex_stall_cnt != 32'd0), 64'd1);
      chk("perf_lu_counted", 64'(perf_lu_stall_cnt != 32'd0), 64'd1);
`endif

      // Reset while BUSY abandons the op
      tick(); idle();
      lu_issue = 1'b1; lu_dst = 5'd8; lu_lat = 6'd5;
      tick(); idle();
      #1;
      chk("lu_pre_reset_mask", 64'(busy_mask), 64'(32'd1 << 8));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst_mid_mask", 64'(busy_mask), 64'd0);
      chk("rst_mid_valid", 64'(lu_wb_valid), 64'd0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
      chk("rst_mid_perf", 64'({perf_id_stall_cnt | perf_ex_stall_cnt | perf_lu_stall_cnt}), 64'd0);
`endif
      repeat (8) tick();
      chk("lu_queue_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard/forward unit.
- Keeps the want/need stall-or-forward rules for ID, EX and MEM over NUM_SRC read ports.
- Adds a registered scoreboard for one non-pipelined long-latency unit (mul/div) that writes back out of band, plus the structural and WAW stalls that unit requires.
- Sits beside the datapath.
- All stall outputs and forward selects are combinational from the inputs and the scoreboard state.

Parameters:
- NUM_REGS, 32: architectural registers. Register 0 is hardwired zero.
- REG_W, 5: register index width, equal to clog2(NUM_REGS).
- NUM_SRC, 2: read ports per instruction (Rs, Rt, ...).
- MAX_LAT, 32: maximum long-unit latency in cycles.
- LAT_W, 6: latency counter width, equal to clog2(MAX_LAT+1).

Ports:
- clock  in  1  Single clock. All state is on the rising edge.
- reset  in  1  Synchronous, active-high. Clears all state.
- id_src  in  NUM_SRC*REG_W  Source registers in ID; port k is at [k*REG_W +: REG_W].
- id_want, id_need  in  NUM_SRC  Per-port want/need in ID.
- ex_src, ex_want, ex_need  in  NUM_SRC*REG_W, NUM_SRC, NUM_SRC  Same three signals for EX.
- ex_dst, mem_dst, wb_dst  in  REG_W  Destination register per stage.
- ex_regwrite, mem_regwrite, wb_regwrite  in  1  Stage writes its destination.
- mem_access  in  1  MEM stage is a load or store-conditional.
- mem_st_src  in  REG_W  Store data register in MEM.
- ex_link  in  1  EX forward selects are forced to 2'b11.
- lu_issue  in  1  ID holds a long-unit op.
- lu_dst  in  REG_W  Destination of that op.
- lu_lat  in  LAT_W  Latency of that op.
- imem_busy  in  1  Instruction fetch not complete.
- dmem_stall  in  1  Data memory controller stall.
- if_stall, id_stall, ex_stall, mem_stall, wb_stall  out  1  Stage stalls.
- id_fwd_sel, ex_fwd_sel  out  NUM_SRC*2  Per-port forward select: 00 register file, 01 MEM, 10 WB, 11 long unit (ID) or link (EX).
- mem_wdata_fwd  out  1  Forward WB data into the store data path.
- lu_wb_valid  out  1  Long-unit result is written to the register file this cycle.
- lu_wb_dst  out  REG_W  Destination register of that write.
- busy_mask  out  NUM_REGS  Bit r set while register r is pending on the long unit.

Behaviour:
- Reset values:
  - FSM is IDLE; counter is 0; pending destination is 0.
  - busy_mask = 0, lu_wb_valid = 0, lu_wb_dst = 0.
  - Stall and forward outputs reflect only the current inputs.
- Match rule: a source matches a stage when all of the following hold:
  - src == dst, and dst != 0;
  - the stage's regwrite is set;
  - want|need is set for that port.
- Pipeline rules, per port:
  - ID need matching EX: stall.
  - ID matching MEM: with mem_access, stall if need; without mem_access, forward 01.
  - ID matching WB: forward 10.
  - EX uses the same rules against MEM and WB.
  - MEM beats WB in priority.
  - mem_wdata_fwd = (mem_st_src == wb_dst) & wb_dst != 0 & wb_regwrite.
- Long-unit FSM:
  - IDLE: on lu_issue & ~id_stall, capture lu_dst, load counter with lu_lat, set busy_mask[lu_dst], go to BUSY.
  - Latency arithmetic: lu_lat of 0 is treated as 1; values above MAX_LAT saturate to MAX_LAT.
  - BUSY: decrement the counter each cycle in which ~wb_stall. When the counter reaches 1, go to DONE.
  - DONE: lu_wb_valid = 1 for one cycle; clear busy_mask; return to IDLE. An issue in this same cycle is accepted (back-to-back).
  - In DONE, ID ports matching the pending destination (wanted or needed) select 11. This has priority below MEM and WB matches.
  - If wb_stall is high while in DONE, hold DONE (lu_wb_valid stays high).
- Scoreboard stalls, added to id_stall:
  - an ID need on a busy register;
  - lu_issue while in BUSY (structural);
  - an ID regwrite op whose lu_dst (same field) equals the pending destination while BUSY (WAW).
- Stall chain:
  - if_stall = imem_busy.
  - mem_stall = if_stall | dmem_stall.
  - wb_stall = mem_stall.
  - ex_stall = EX stalls | mem_stall.
  - id_stall = ID stalls | ex_stall.
- Register 0: a long-unit op with lu_dst = 0 still occupies the unit but never sets any busy bit.
- Reset mid-operation: the pending op is abandoned; no lu_wb_valid pulse is produced.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_PERF_EN.
- When defined, adds outputs perf_id_stall_cnt, perf_ex_stall_cnt and perf_lu_stall_cnt, each 32 bits. They count cycles in which, respectively:
  - the ID-originated stall term is high;
  - the EX-originated stall term is high;
  - the scoreboard stall term is high.
- Counters saturate at all-ones and are cleared by reset.
- When not defined, the ports and logic are absent. Functional behaviour is identical either way.

Decomposition:
- Shared package cpu_hazard_pkg holds:
  - the forward-select encodings FWD_RF, FWD_MEM, FWD_WB, FWD_ALT;
  - the FSM state enum LU_IDLE, LU_BUSY, LU_DONE.
- One sub-module, hazard_port_match. It is instantiated per port per stage and produces the stall and fwd_sel for one source.
- The top level contains the FSM, the counter, the busy mask and the stall chain.

Test Plan:
- ID Rs=3 need, EX dst=3 regwrite -> id_stall=1, ex_stall=0, id_fwd_sel[1:0]=00.
- EX Rt=5 want, MEM dst=5 regwrite with mem_access=0, WB dst=5 -> ex_fwd_sel[3:2]=01. Then set mem_access=1 with need -> ex_stall=1.
- lu_issue dst=7 lat=4 -> busy_mask[7]=1 for 4 cycles. ID need on r7 stalls for that period. lu_wb_valid pulses in cycle 4 with lu_wb_dst=7, and ID port r7 selects 11.
- Second lu_issue while BUSY -> id_stall=1 until DONE. Issue in the DONE cycle is accepted: busy_mask moves to the new destination.
- dmem_stall=1 while BUSY with lat=3 -> counter frozen; lu_wb_valid is delayed by exactly the number of stalled cycles.
- reset asserted while BUSY -> next cycle busy_mask=0, FSM IDLE, no lu_wb_valid pulse. With the PERF macro defined, all counters read 0.
